// File: rtl/board_io_ctrl_if.sv
// Front-panel signal bundle: switches and raw buttons in, LEDs and
// multiplexed seven-segment display out.
interface board_io_ctrl_if #(
    parameter int SW_W = 8,
    parameter int NDIG = 4
);
    logic [SW_W-1:0] switches;
    logic            bBottom;
    logic            bLeft;
    logic            bRight;
    logic [SW_W-1:0] leds;
    logic [NDIG-1:0] anodes;
    logic [7:0]      SSD;

    modport master (
        output switches, bBottom, bLeft, bRight,
        input  leds, anodes, SSD
    );

    modport slave (
        input  switches, bBottom, bLeft, bRight,
        output leds, anodes, SSD
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Front-panel controller: debounced buttons drive a clear/add/subtract
// accumulator shown on LEDs and as hex on a scanned seven-segment display.
module board_io_ctrl #(
    parameter int SW_W     = 8,
    parameter int NDIG     = 4,
    parameter int DEB_CYC  = 16,
    parameter int SCAN_DIV = 1024
) (
    input  logic           x1,
    input  logic           rst,
    board_io_ctrl_if.slave io
);
    localparam int ACC_W   = 4 * NDIG;
    localparam int CNT_W   = $clog2(DEB_CYC + 1);
    localparam int PRE_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int NBTN    = 3;
    localparam int BTN_CLR = 0;
    localparam int BTN_ADD = 1;
    localparam int BTN_SUB = 2;

    // Active-low {g..a} glyphs for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [NBTN-1:0]            btn_raw;
    logic [NBTN-1:0]            sync1_q, sync1_d;
    logic [NBTN-1:0]            sync2_q, sync2_d;
    logic [NBTN-1:0]            deb_q, deb_d;
    logic [NBTN-1:0]            deb_dly_q, deb_dly_d;
    logic [NBTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NBTN-1:0]            press;

    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       ovf_q, ovf_d;
    logic [ACC_W-1:0]           sw_ext;
    logic [ACC_W:0]             sum_w;
    logic [ACC_W:0]             diff_w;

    logic [PRE_W-1:0]           pre_q, pre_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NDIG-1:0]            anodes_q, anodes_d;
    logic [7:0]                 ssd_q, ssd_d;
    logic [3:0]                 nib;

    assign btn_raw = {io.bRight, io.bLeft, io.bBottom};

    // Synchroniser and debounce: the counter measures how long the
    // synchronised level has disagreed with the accepted level.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        for (int b = 0; b < NBTN; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == CNT_W'(DEB_CYC - 1)) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

    // The extra top bit of the sum/difference is the carry/borrow.
    always_comb begin
        sw_ext              = '0;
        sw_ext[SW_W-1:0]    = io.switches;
        sum_w               = {1'b0, acc_q} + {1'b0, sw_ext};
        diff_w              = {1'b0, acc_q} - {1'b0, sw_ext};
        acc_d               = acc_q;
        ovf_d               = ovf_q;
        if (press[BTN_CLR]) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (press[BTN_ADD]) begin
            acc_d = sum_w[ACC_W-1:0];
            ovf_d = ovf_q | sum_w[ACC_W];
        end else if (press[BTN_SUB]) begin
            acc_d = diff_w[ACC_W-1:0];
            ovf_d = ovf_q | diff_w[ACC_W];
        end
    end

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        nib = acc_q[3:0];
        for (int d = 0; d < NDIG; d++) begin
            if (idx_q == IDX_W'(d)) begin
                nib = acc_q[4*d +: 4];
            end
        end

        anodes_d = ~(NDIG'(1) << idx_q);
        ssd_d    = {~((idx_q == '0) && ovf_q), hex_glyph(nib)};
    end

    always_ff @(posedge x1 or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            pre_q     <= '0;
            idx_q     <= '0;
            anodes_q  <= '1;
            ssd_q     <= 8'hFF;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            anodes_q  <= anodes_d;
            ssd_q     <= ssd_d;
        end
    end

    assign io.leds   = acc_q[SW_W-1:0];
    assign io.anodes = anodes_q;
    assign io.SSD    = ssd_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Bench for board_io_ctrl: event-level model of buttons, accumulator and
// scan, checked every cycle, plus directed literal expectations.
module tb_board_io_ctrl;
    localparam int SW_W     = 8;
    localparam int NDIG     = 4;
    localparam int DEB_CYC  = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic x1  = 1'b0;
    logic rst = 1'b0;

    board_io_ctrl_if #(.SW_W(SW_W), .NDIG(NDIG)) io ();

    board_io_ctrl #(
        .SW_W(SW_W), .NDIG(NDIG), .DEB_CYC(DEB_CYC), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .x1 (x1),
        .rst(rst),
        .io (io)
    );

    always #5 x1 = ~x1;

    int errors = 0;
    int checks = 0;

    // Model state: accepted button levels, run lengths of disagreement,
    // presses waiting to act, accumulator, and expected display.
    logic [15:0] m_acc   = '0;
    logic        m_ovf   = 1'b0;
    logic [3:0]  exp_an  = 4'hF;
    logic [7:0]  exp_ssd = 8'hFF;
    logic [2:0]  h1 = '0, h2 = '0, deb = '0, pend = '0;
    int          run [3];
    int          ecnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_ovf = 1'b0; exp_an = 4'hF; exp_ssd = 8'hFF;
        h1 = '0; h2 = '0; deb = '0; pend = '0; ecnt = 0;
        for (int b = 0; b < 3; b++) run[b] = 0;
    endtask

    task automatic model_step();
        int idx;
        int wide;
        logic [3:0] nib;
        logic [7:0] sw;
        ecnt++;
        idx     = ((ecnt - 1) / SCAN_DIV) % NDIG;
        exp_an  = ~(4'b0001 << idx);
        nib     = 4'((m_acc >> (4 * idx)) & 16'hF);
        exp_ssd = GLYPH[nib];
        if (idx == 0 && m_ovf) exp_ssd[7] = 1'b0;
        sw = io.switches;
        if (pend[0]) begin
            m_acc = '0; m_ovf = 1'b0;
        end else if (pend[1]) begin
            wide = int'(m_acc) + int'(sw);
            if (wide > 65535) m_ovf = 1'b1;
            m_acc = 16'(wide);
        end else if (pend[2]) begin
            if (16'(sw) > m_acc) m_ovf = 1'b1;
            m_acc = m_acc - 16'(sw);
        end
        pend = '0;
        for (int b = 0; b < 3; b++) begin
            if (h2[b] != deb[b]) begin
                run[b]++;
                if (run[b] == DEB_CYC) begin
                    deb[b] = h2[b];
                    run[b] = 0;
                    if (h2[b]) pend[b] = 1'b1;
                end
            end else begin
                run[b] = 0;
            end
        end
        h2 = h1;
        h1 = {io.bRight, io.bLeft, io.bBottom};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge x1 or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge x1);
            chk("leds",   io.leds,   m_acc[7:0]);
            chk("anodes", io.anodes, exp_an);
            chk("ssd",    io.SSD,    exp_ssd);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge x1);
            #1;
        end
    endtask

    task automatic press(input logic [2:0] mask, input logic [7:0] sw, input int hold);
        io.switches = sw;
        {io.bRight, io.bLeft, io.bBottom} = mask;
        step(hold);
        {io.bRight, io.bLeft, io.bBottom} = 3'b000;
        step(12);
    endtask

    task automatic expect_digit(input string name, input logic [3:0] an, input logic [7:0] ssd);
        int k;
        k = 0;
        while (io.anodes !== an && k < 40) begin
            step(1);
            k++;
        end
        if (io.anodes !== an) chk({name, "_scan_timeout"}, io.anodes, an);
        else                  chk(name, io.SSD, ssd);
    endtask

    initial begin
        io.switches = '0;
        io.bBottom  = 1'b0;
        io.bLeft    = 1'b0;
        io.bRight   = 1'b0;
        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("rst_anodes", io.anodes, 4'hF);
        chk("rst_ssd",    io.SSD,    8'hFF);
        chk("rst_leds",   io.leds,   8'h00);
        step(1);
        chk("first_anodes", io.anodes, 4'b1110);
        chk("first_ssd",    io.SSD,    8'hC0);
        step(4);
        chk("rot1", io.anodes, 4'b1101);
        step(4);
        chk("rot2", io.anodes, 4'b1011);
        step(4);
        chk("rot3", io.anodes, 4'b0111);
        step(4);
        chk("rot0", io.anodes, 4'b1110);

        io.switches = 8'h35;
        io.bLeft    = 1'b1;
        step(6);
        chk("add_early", io.leds, 8'h00);
        step(1);
        chk("add_latency", io.leds, 8'h35);
        step(3);
        io.bLeft = 1'b0;
        step(14);
        chk("add_once", io.leds, 8'h35);
        chk("model_acc_35", m_acc, 16'h0035);
        expect_digit("dig1_3", 4'b1101, 8'hB0);
        expect_digit("dig0_5", 4'b1110, 8'h92);

        io.bLeft = 1'b1; step(1);
        io.bLeft = 1'b0; step(1);
        io.bLeft = 1'b1; step(1);
        io.bLeft = 1'b0;
        step(15);
        chk("bounce_reject", io.leds, 8'h35);
        press(3'b010, 8'h01, 8);
        chk("clean_add", io.leds, 8'h36);

        press(3'b001, 8'h00, 8);
        chk("clear", io.leds, 8'h00);
        press(3'b100, 8'h01, 8);
        chk("sub_wrap", io.leds, 8'hFF);
        chk("model_ffff", m_acc, 16'hFFFF);
        expect_digit("dp_on_F", 4'b1110, 8'h0E);
        expect_digit("dig3_F",  4'b0111, 8'h8E);
        press(3'b010, 8'h02, 8);
        chk("add_wrap", io.leds, 8'h01);
        expect_digit("ovf_sticky", 4'b1110, 8'h79);
        press(3'b001, 8'h00, 8);
        chk("clear2", io.leds, 8'h00);
        expect_digit("dp_off", 4'b1110, 8'hC0);

        press(3'b010, 8'h05, 8);
        chk("pre_simul", io.leds, 8'h05);
        press(3'b101, 8'h05, 8);
        chk("simul_clear", io.leds, 8'h00);
        step(20);
        chk("simul_no_sub", io.leds, 8'h00);
        expect_digit("simul_dig3", 4'b0111, 8'hC0);

        io.switches = 8'h07;
        io.bLeft    = 1'b1;
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);
        chk("rstpress_early", io.leds, 8'h00);
        step(1);
        chk("rstpress_add", io.leds, 8'h07);
        step(3);
        io.bLeft = 1'b0;
        step(14);
        chk("rstpress_once", io.leds, 8'h07);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised front-panel controller for the lab board. It debounces the push-buttons and keeps an accumulator that the buttons clear, add to or subtract from using the switch value. It shows the accumulator low bits on the LEDs and the full accumulator as hex on a multiplexed seven-segment display. It replaces the fixed 8-switch/4-digit LED module as the top-level I/O block.

## Interface
- SW_W, 8, switch and LED width; must satisfy 1 <= SW_W <= 4*NDIG
- NDIG, 4, number of seven-segment digits; accumulator width is 4*NDIG
- DEB_CYC, 16, consecutive stable cycles needed to accept a button change (>= 2)
- SCAN_DIV, 1024, clock cycles each digit stays lit (>= 2)

- x1  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- switches  in  SW_W  operand value, sampled at the cycle of the action
- bBottom  in  1  raw button, clear action
- bLeft  in  1  raw button, add action
- bRight  in  1  raw button, subtract action
- leds  out  SW_W  accumulator bits [SW_W-1:0]
- anodes  out  NDIG  digit enables, active-low, one-hot
- SSD  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- **Button path (per button, identical)**
  - 2-FF synchroniser, then a debounce counter of width clog2(DEB_CYC+1).
  - Counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEB_CYC-1 and the mismatch persists, the debounced level toggles and the counter clears.
  - A debounced 0->1 transition generates a one-cycle press pulse. Release generates no pulse.
- **Accumulator acc (4*NDIG bits)**, updated on press pulses. When pulses coincide, priority is clear > add > subtract:
  - clear: acc <= 0, ovf <= 0.
  - add: acc <= acc + zero-extended switches, modulo 2^(4*NDIG). ovf <= 1 on carry out.
  - subtract: acc <= acc - zero-extended switches, modulo 2^(4*NDIG). ovf <= 1 on borrow.
  - ovf is sticky and is cleared only by clear or rst.
- **leds**: driven directly from acc[SW_W-1:0] with no extra register.
- **Display scan**
  - Prescaler counts 0..SCAN_DIV-1. At its terminal count it wraps and advances the digit index: 0,1,...,NDIG-1,0.
  - anodes and SSD are registered from the current index. anodes[i] = 0 only for i == index.
  - SSD[6:0] is the hex glyph of acc[4*index+3:4*index], active-low, standard segments: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, given as {g..a} with dp=1.
  - dp (SSD[7]) = 0 only when index == 0 and ovf == 1.
  - acc changes are reflected on the next clock edge for whichever digit is lit; the scan position is not disturbed.

## Timing
- **Reset values (asynchronous):**
  - acc=0, ovf=0, leds=0
  - anodes=all ones, SSD=8'hFF
  - prescaler=0, digit index=0
  - all synchronisers, debounced levels and counters=0
- **After rst deasserts**: the first rising edge loads anodes/SSD for digit 0. With acc=0 this gives anodes=~1, SSD=8'hC0.
- **Press latency**: a raw button held high from edge k produces acc/leds update at edge k+DEB_CYC+3. That is 2 synchroniser edges + DEB_CYC debounce edges + 1 accumulator edge.
- **Glitch rejection**: a raw pulse shorter than DEB_CYC cycles after synchronisation causes no action.
- **Holding a button**: yields exactly one action. A new action requires a debounced release and a new press.
- **Switch sampling**: switches are sampled combinationally at the edge the accumulator updates. They have no synchroniser, so the operator must hold them steady.
- **Digit dwell**: each digit is lit exactly SCAN_DIV cycles. A full scan takes NDIG*SCAN_DIV cycles.
- **Reset mid-debounce or mid-scan**: all state is abandoned immediately. No action fires from a press in progress.

## Test plan
- Params DEB_CYC=4, SCAN_DIV=4, SW_W=8, NDIG=4 are used for all cases.
- Reset: assert rst for 3 cycles, then release -> leds=00, anodes=1110, SSD=C0 from the first edge. Digits rotate 1101, 1011, 0111 every 4 cycles.
- Add: switches=8'h35, bLeft high 10 cycles -> acc=0x0035 exactly 7 edges after the press start, leds=35. Digit 1 shows B0 (3), digit 0 shows 92 (5). Only one add occurs.
- Bounce: bLeft toggles 1,0,1,0 at 1-cycle intervals, then stays low -> acc unchanged. Then a clean press with switches=01 -> acc +1.
- Wrap/overflow: acc=0xFFFF via a clear then subtracts (0-1), checking borrow sets dp on digit 0 (SSD=0x0E for F with dp). A following add of 02 gives acc=0x0001, with ovf still 1. bBottom -> acc=0, dp off.
- Simultaneous: bBottom and bRight pressed on the same cycle -> clear wins, acc=0, no subtract follows.
- Reset mid-press: rst asserted 2 cycles after bLeft goes high, then released with bLeft still high -> exactly one add, DEB_CYC+3 edges after release.
